// File: rtl/vboard_mem_responder.sv
// rtl/vboard_mem_responder.sv - word-addressed RAM responder with wait states and byte-lane writes
// Optional out-of-range checking and digital_mem_err port: define VBOARD_MEM_BOUNDS_CHK_EN
module vboard_mem_responder #(
  parameter int DEPTH_WORDS = 16384,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digital_mem_addr,
  input  logic        digital_mem_write_en,
  input  logic        digital_mem_read_en,
  input  logic [3:0]  digital_mem_byte_size,
  input  logic [31:0] digital_mem_wdata,
  output logic [31:0] digital_mem_data,
  output logic        digital_mem_ready
`ifdef VBOARD_MEM_BOUNDS_CHK_EN
  ,
  output logic        digital_mem_err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef VBOARD_MEM_BOUNDS_CHK_EN
  localparam int WORD_W = 30;
`else
  localparam int WORD_W = AW;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WORD_W-1:0]   word_q;
  logic [3:0]          mask_q;
  logic [31:0]         wdata_q;
  logic                is_write_q;
  logic                capture;
  logic                do_access;
  logic                in_range;
  logic [AW-1:0]       idx;
  logic [31:0]         mem [DEPTH_WORDS];

  // Byte-offset bits (and upper bits when wrapping) are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^digital_mem_addr;

  assign idx = word_q[AW-1:0];
`ifdef VBOARD_MEM_BOUNDS_CHK_EN
  assign in_range = (word_q < 30'(DEPTH_WORDS));
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (digital_mem_write_en || digital_mem_read_en) begin
          capture = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        do_access = 1'b1;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        // Wait for the requester to release so a held level fires only once.
        if (!digital_mem_write_en && !digital_mem_read_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      word_q     <= '0;
      mask_q     <= 4'd0;
      wdata_q    <= 32'd0;
      is_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        word_q     <= digital_mem_addr[WORD_W+1:2];
        mask_q     <= digital_mem_byte_size;
        wdata_q    <= digital_mem_wdata;
        is_write_q <= digital_mem_write_en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digital_mem_ready <= 1'b0;
      digital_mem_data  <= 32'd0;
`ifdef VBOARD_MEM_BOUNDS_CHK_EN
      digital_mem_err   <= 1'b0;
`endif
    end else begin
      digital_mem_ready <= do_access;
      if (do_access && !is_write_q) digital_mem_data <= in_range ? mem[idx] : 32'd0;
`ifdef VBOARD_MEM_BOUNDS_CHK_EN
      digital_mem_err   <= do_access && !in_range;
`endif
    end
  end

  // Storage is not reset; an async reset forces IDLE so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (do_access && is_write_q && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
